// File: rtl/friscv_axi_pkg.sv
// Shared AXI4-lite definitions for the FRISCV memory path: response codes,
// the AR field bundle and small sizing helpers.
package friscv_axi_pkg;

    localparam int PLAT_ADDR_W = 32;
    localparam int PLAT_ID_W   = 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Field widths follow the platform bus, which every FRISCV port shares.
    typedef struct packed {
        logic [PLAT_ADDR_W-1:0] addr;
        logic [2:0]             prot;
        logic [PLAT_ID_W-1:0]   id;
    } axi_ar_t;

    // Set bits in an ID routing tag; a usable tag has exactly one.
    function automatic int mask_popcnt(input logic [31:0] m);
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) n += int'(m[i]);
        return n;
    endfunction

    // Counter width able to hold 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/friscv_axi4l_rd_arbiter_if.sv
// AXI4-lite read channels (AR + R) bundled for the read arbiter ports.
interface friscv_axi4l_rd_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int ID_W   = 8,
    parameter int DATA_W = 128
);
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic [ID_W-1:0]   arid;
    logic              rvalid;
    logic              rready;
    logic [ID_W-1:0]   rid;
    logic [1:0]        rresp;
    logic [DATA_W-1:0] rdata;

    modport master (
        output arvalid, araddr, arprot, arid, rready,
        input  arready, rvalid, rid, rresp, rdata
    );

    modport slave (
        input  arvalid, araddr, arprot, arid, rready,
        output arready, rvalid, rid, rresp, rdata
    );
endinterface

// File: rtl/friscv_axi4l_rd_arbiter_rr.sv
// Two-requester round-robin arbiter; the pointer flips to the other port
// after every grant so a busy port cannot starve its neighbour.
module friscv_rr_arbiter2 (
    input  logic       aclk,
    input  logic       areset,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic ptr_q, ptr_d;  // 0: port 0 wins a tie

    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            if (req_i == 2'b11) gnt_o = ptr_q ? 2'b10 : 2'b01;
            else                gnt_o = req_i;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (|gnt_o) ptr_d = gnt_o[0];
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) ptr_q <= 1'b0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/friscv_axi4l_rd_arbiter.sv
// Merges instruction-fetch and data read ports onto one AXI4-lite read port.
// Sources are tagged in ARID and responses routed back by decoding RID.
module friscv_axi4l_rd_arbiter
    import friscv_axi_pkg::*;
#(
    parameter int                  AXI_ADDR_W  = PLAT_ADDR_W,
    parameter int                  AXI_ID_W    = PLAT_ID_W,
    parameter int                  AXI_DATA_W  = 128,
    parameter logic [AXI_ID_W-1:0] S1_MASK     = 'h10,
    parameter logic [AXI_ID_W-1:0] S2_MASK     = 'h20,
    parameter int                  OSTDREQ_NUM = 8
)(
    input  logic                              aclk,
    input  logic                              areset,
    friscv_axi4l_rd_arbiter_if.slave          s1,
    friscv_axi4l_rd_arbiter_if.slave          s2,
    friscv_axi4l_rd_arbiter_if.master         m,
    output logic                              unrouted_err
);

    localparam int                  CNT_W    = cnt_width(OSTDREQ_NUM);
    localparam logic [CNT_W-1:0]    CNT_MAX  = CNT_W'(OSTDREQ_NUM);
    localparam logic [AXI_ID_W-1:0] TAG_MASK = S1_MASK | S2_MASK;

    logic                  arvld_q, arvld_d;
    axi_ar_t               ar_q, ar_d;
    logic                  load_en;
    logic [1:0]            req, gnt;
    logic [1:0]            inc, dec;
    logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic                  hit1, hit2;
    logic                  err_q, err_d;

    // Holding slot refills as soon as the current beat leaves, no bubble.
    assign load_en = !arvld_q || m.arready;

    assign req[0] = s1.arvalid && (cnt_q[0] < CNT_MAX);
    assign req[1] = s2.arvalid && (cnt_q[1] < CNT_MAX);

    friscv_rr_arbiter2 u_rr (
        .aclk   (aclk),
        .areset (areset),
        .en_i   (load_en),
        .req_i  (req),
        .gnt_o  (gnt)
    );

    assign s1.arready = gnt[0];
    assign s2.arready = gnt[1];

    always_comb begin
        arvld_d = arvld_q;
        ar_d    = ar_q;
        if (load_en) begin
            arvld_d = |gnt;
            if (gnt[0]) begin
                ar_d.addr = s1.araddr;
                ar_d.prot = s1.arprot;
                ar_d.id   = s1.arid | S1_MASK;
            end else if (gnt[1]) begin
                ar_d.addr = s2.araddr;
                ar_d.prot = s2.arprot;
                ar_d.id   = s2.arid | S2_MASK;
            end
        end
    end

    assign m.arvalid = arvld_q;
    assign m.araddr  = ar_q.addr;
    assign m.arprot  = ar_q.prot;
    assign m.arid    = ar_q.id;

    // S1 tag takes precedence if a malformed RID carries both tags.
    assign hit1 = |(m.rid & S1_MASK);
    assign hit2 = !hit1 && |(m.rid & S2_MASK);

    assign s1.rvalid = m.rvalid && hit1;
    assign s1.rid    = m.rid & ~TAG_MASK;
    assign s1.rresp  = m.rresp;
    assign s1.rdata  = m.rdata;
    assign s2.rvalid = m.rvalid && hit2;
    assign s2.rid    = m.rid & ~TAG_MASK;
    assign s2.rresp  = m.rresp;
    assign s2.rdata  = m.rdata;

    // Unrouted beats are swallowed so the memory never stalls on them.
    assign m.rready = hit1 ? s1.rready : (hit2 ? s2.rready : 1'b1);

    assign inc    = gnt;
    assign dec[0] = s1.rvalid && s1.rready;
    assign dec[1] = s2.rvalid && s2.rready;

    for (genvar i = 0; i < 2; i++) begin : g_cnt
        always_comb begin
            cnt_d[i] = cnt_q[i];
            if (inc[i] && !dec[i])      cnt_d[i] = cnt_q[i] + 1'b1;
            else if (!inc[i] && dec[i]) cnt_d[i] = cnt_q[i] - 1'b1;
        end
    end

    assign err_d        = err_q || (m.rvalid && !hit1 && !hit2);
    assign unrouted_err = err_q;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            arvld_q <= 1'b0;
            ar_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            arvld_q <= arvld_d;
            ar_q    <= ar_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_friscv_axi4l_rd_arbiter.sv
// Directed bench for the two-port AXI4-lite read arbiter with AR and R
// scoreboards checked by free-running monitors.
module tb_friscv_axi4l_rd_arbiter;
    import friscv_axi_pkg::*;

    logic aclk = 1'b0;
    logic areset = 1'b1;
    logic unrouted_err;
    always #5 aclk = ~aclk;

    friscv_axi4l_rd_arbiter_if #(.ADDR_W(32), .ID_W(8), .DATA_W(128)) s1_if ();
    friscv_axi4l_rd_arbiter_if #(.ADDR_W(32), .ID_W(8), .DATA_W(128)) s2_if ();
    friscv_axi4l_rd_arbiter_if #(.ADDR_W(32), .ID_W(8), .DATA_W(128)) m_if ();

    friscv_axi4l_rd_arbiter #(
        .AXI_ADDR_W(32), .AXI_ID_W(8), .AXI_DATA_W(128),
        .S1_MASK(8'h10), .S2_MASK(8'h20), .OSTDREQ_NUM(8)
    ) dut (
        .aclk(aclk), .areset(areset),
        .s1(s1_if), .s2(s2_if), .m(m_if),
        .unrouted_err(unrouted_err)
    );

    typedef struct { logic [31:0] addr; logic [7:0] id; logic [2:0] prot; } ar_exp_t;
    typedef struct { int port; logic [7:0] id; logic [127:0] data; logic [1:0] resp; } r_exp_t;

    ar_exp_t ar_sb[$];
    r_exp_t  r_sb[$];
    int tests = 0;
    int fails = 0;

    logic [1:0]  t2_gnt  [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [31:0] t2_addr [4] = '{32'h200, 32'h304, 32'h208, 32'h30C};
    logic [7:0]  t2_id   [4] = '{8'h12, 8'h23, 8'h12, 8'h23};

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_ar(input logic [31:0] a, input logic [7:0] id, input logic [2:0] pr);
        ar_exp_t e;
        e.addr = a; e.id = id; e.prot = pr;
        ar_sb.push_back(e);
    endtask

    task automatic push_r(input int p, input logic [7:0] id, input logic [127:0] d, input logic [1:0] rs);
        r_exp_t e;
        e.port = p; e.id = id; e.data = d; e.resp = rs;
        r_sb.push_back(e);
    endtask

    task automatic r_check(input int p, input logic [7:0] id, input logic [1:0] rs, input logic [127:0] d);
        r_exp_t e;
        chk("cnt_nonzero_on_retire", 128'(dut.cnt_q[p-1] != '0), 128'(1));
        if (r_sb.size() == 0) begin
            tests++; fails++;
            $display("FAIL r_unexpected: got beat on s%0d id 0x%0h, want none", p, id);
        end else begin
            e = r_sb.pop_front();
            chk("r_port", 128'(p), 128'(e.port));
            chk("r_id", 128'(id), 128'(e.id));
            chk("r_resp", 128'(rs), 128'(e.resp));
            chk("r_data", d, e.data);
        end
    endtask

    // AR monitor: every shared-port handshake must match the next expected beat.
    always @(negedge aclk) begin
        ar_exp_t e;
        if (!areset) begin
            if (m_if.arvalid && m_if.arready) begin
                if (ar_sb.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL m_ar_unexpected: got addr 0x%0h id 0x%0h, want none", m_if.araddr, m_if.arid);
                end else begin
                    e = ar_sb.pop_front();
                    chk("m_araddr", 128'(m_if.araddr), 128'(e.addr));
                    chk("m_arid", 128'(m_if.arid), 128'(e.id));
                    chk("m_arprot", 128'(m_if.arprot), 128'(e.prot));
                end
            end
            if (s1_if.rvalid && s1_if.rready) r_check(1, s1_if.rid, s1_if.rresp, s1_if.rdata);
            if (s2_if.rvalid && s2_if.rready) r_check(2, s2_if.rid, s2_if.rresp, s2_if.rdata);
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got no finish, want finish before 50000ns");
        $fatal(1);
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle();
        s1_if.arvalid = 0; s1_if.araddr = 0; s1_if.arprot = 0; s1_if.arid = 0; s1_if.rready = 0;
        s2_if.arvalid = 0; s2_if.araddr = 0; s2_if.arprot = 0; s2_if.arid = 0; s2_if.rready = 0;
        m_if.arready = 0; m_if.rvalid = 0; m_if.rid = 0; m_if.rresp = 0; m_if.rdata = 0;
    endtask

    task automatic do_reset();
        idle();
        areset = 1;
        step();
        areset = 0;
        step();
    endtask

    initial begin
        idle();
        step();
        chk("rst_m_arvalid", 128'(m_if.arvalid), 0);
        chk("rst_m_araddr", 128'(m_if.araddr), 0);
        chk("rst_m_arid", 128'(m_if.arid), 0);
        chk("rst_unrouted_err", 128'(unrouted_err), 0);
        areset = 0;
        step();

        // 1: single s1 read and its response
        m_if.arready = 1;
        s1_if.arvalid = 1; s1_if.araddr = 32'h100; s1_if.arid = 8'h01; s1_if.arprot = 3'b010;
        #1;
        chk("t1_s1_arready", 128'(s1_if.arready), 1);
        chk("t1_s2_arready", 128'(s2_if.arready), 0);
        push_ar(32'h100, 8'h11, 3'b010);
        step();
        s1_if.arvalid = 0;
        #1;
        chk("t1_m_arvalid", 128'(m_if.arvalid), 1);
        chk("t1_m_arid", 128'(m_if.arid), 128'h11);
        step();
        m_if.rvalid = 1; m_if.rid = 8'h11; m_if.rdata = 128'hA5; m_if.rresp = RESP_OKAY; s1_if.rready = 1;
        push_r(1, 8'h01, 128'hA5, RESP_OKAY);
        #1;
        chk("t1_s1_rvalid", 128'(s1_if.rvalid), 1);
        chk("t1_s2_rvalid", 128'(s2_if.rvalid), 0);
        chk("t1_m_rready", 128'(m_if.rready), 1);
        chk("t1_s1_rid", 128'(s1_if.rid), 128'h01);
        step();
        m_if.rvalid = 0; s1_if.rready = 0;
        #1;
        chk("t1_m_arvalid_idle", 128'(m_if.arvalid), 0);

        // 2: both ports requesting, grants alternate with no bubble
        do_reset();
        m_if.arready = 1;
        s1_if.arvalid = 1; s1_if.arid = 8'h02;
        s2_if.arvalid = 1; s2_if.arid = 8'h03;
        for (int i = 0; i < 4; i++) begin
            s1_if.araddr = 32'h200 + 32'(4 * i);
            s2_if.araddr = 32'h300 + 32'(4 * i);
            #1;
            chk("t2_grant", 128'({s2_if.arready, s1_if.arready}), 128'(t2_gnt[i]));
            push_ar(t2_addr[i], t2_id[i], 3'b000);
            if (i > 0) chk("t2_no_bubble", 128'(m_if.arvalid), 1);
            step();
        end
        s1_if.arvalid = 0; s2_if.arvalid = 0;
        step();

        // 3: backpressure holds the slot stable and blocks new grants
        do_reset();
        s1_if.arvalid = 1; s1_if.araddr = 32'h400; s1_if.arid = 8'h04; s1_if.arprot = 3'b001;
        #1;
        chk("t3_first_grant", 128'(s1_if.arready), 1);
        push_ar(32'h400, 8'h14, 3'b001);
        step();
        s1_if.araddr = 32'h440; s1_if.arprot = 3'b000;
        s2_if.arvalid = 1; s2_if.araddr = 32'h500; s2_if.arid = 8'h05; s2_if.arprot = 3'b000;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t3_hold_arvalid", 128'(m_if.arvalid), 1);
            chk("t3_hold_araddr", 128'(m_if.araddr), 128'h400);
            chk("t3_hold_arid", 128'(m_if.arid), 128'h14);
            chk("t3_no_grant", 128'({s2_if.arready, s1_if.arready}), 0);
            step();
        end
        m_if.arready = 1;
        #1;
        chk("t3_release_grant", 128'({s2_if.arready, s1_if.arready}), 128'b10);
        push_ar(32'h500, 8'h25, 3'b000);
        step();
        s2_if.arvalid = 0;
        #1;
        chk("t3_next_grant", 128'({s2_if.arready, s1_if.arready}), 128'b01);
        push_ar(32'h440, 8'h14, 3'b000);
        step();
        s1_if.arvalid = 0;
        step();

        // 4: s2 reaches its outstanding limit, s1 still served
        do_reset();
        m_if.arready = 1;
        s2_if.arvalid = 1; s2_if.arid = 8'h07;
        for (int i = 0; i < 8; i++) begin
            s2_if.araddr = 32'h1000 + 32'(4 * i);
            #1;
            chk("t4_fill_grant", 128'(s2_if.arready), 1);
            push_ar(32'h1000 + 32'(4 * i), 8'h27, 3'b000);
            step();
        end
        s2_if.araddr = 32'h1020;
        s1_if.arvalid = 1; s1_if.araddr = 32'h2000; s1_if.arid = 8'h01;
        #1;
        chk("t4_s2_stalled", 128'(s2_if.arready), 0);
        chk("t4_s1_granted", 128'(s1_if.arready), 1);
        push_ar(32'h2000, 8'h11, 3'b000);
        step();
        s1_if.arvalid = 0;
        #1;
        chk("t4_s2_still_stalled", 128'(s2_if.arready), 0);
        m_if.rvalid = 1; m_if.rid = 8'h27; m_if.rdata = 128'hD0; m_if.rresp = RESP_SLVERR; s2_if.rready = 1;
        push_r(2, 8'h07, 128'hD0, RESP_SLVERR);
        #1;
        chk("t4_stall_during_retire", 128'(s2_if.arready), 0);
        chk("t4_s1_rvalid_off", 128'(s1_if.rvalid), 0);
        step();
        m_if.rvalid = 0; s2_if.rready = 0;
        #1;
        chk("t4_unstall_grant", 128'(s2_if.arready), 1);
        push_ar(32'h1020, 8'h27, 3'b000);
        step();
        s2_if.arvalid = 0;
        step();

        // 5: issue and retire on s1 in one cycle leave the count at 3
        do_reset();
        m_if.arready = 1;
        s1_if.arvalid = 1; s1_if.arid = 8'h03;
        for (int i = 0; i < 3; i++) begin
            s1_if.araddr = 32'h3000 + 32'(4 * i);
            #1;
            chk("t5_issue", 128'(s1_if.arready), 1);
            push_ar(32'h3000 + 32'(4 * i), 8'h13, 3'b000);
            step();
        end
        s1_if.araddr = 32'h300C;
        m_if.rvalid = 1; m_if.rid = 8'h13; m_if.rdata = 128'h5A5A; m_if.rresp = RESP_OKAY; s1_if.rready = 1;
        push_r(1, 8'h03, 128'h5A5A, RESP_OKAY);
        #1;
        chk("t5_issue_retire", 128'(s1_if.arready), 1);
        push_ar(32'h300C, 8'h13, 3'b000);
        step();
        m_if.rvalid = 0; s1_if.rready = 0;
        for (int i = 0; i < 5; i++) begin
            s1_if.araddr = 32'h3010 + 32'(4 * i);
            #1;
            chk("t5_headroom", 128'(s1_if.arready), 1);
            push_ar(32'h3010 + 32'(4 * i), 8'h13, 3'b000);
            step();
        end
        #1;
        chk("t5_limit", 128'(s1_if.arready), 0);
        s1_if.arvalid = 0;
        step();

        // 6: unrouted beat is sunk and flagged; reset mid-transaction clears all
        m_if.rvalid = 1; m_if.rid = 8'h05; m_if.rdata = 128'h77;
        #1;
        chk("t6_m_rready", 128'(m_if.rready), 1);
        chk("t6_s1_rvalid", 128'(s1_if.rvalid), 0);
        chk("t6_s2_rvalid", 128'(s2_if.rvalid), 0);
        chk("t6_err_before", 128'(unrouted_err), 0);
        step();
        m_if.rvalid = 0;
        #1;
        chk("t6_err_set", 128'(unrouted_err), 1);
        step();
        chk("t6_err_held", 128'(unrouted_err), 1);
        m_if.arready = 0;
        s2_if.arvalid = 1; s2_if.araddr = 32'h6000; s2_if.arid = 8'h06;
        #1;
        chk("t6_s2_grant", 128'(s2_if.arready), 1);
        step();
        s2_if.arvalid = 0;
        #1;
        chk("t6_m_arvalid_pending", 128'(m_if.arvalid), 1);
        areset = 1;
        #1;
        chk("t6_rst_arvalid", 128'(m_if.arvalid), 0);
        chk("t6_rst_arid", 128'(m_if.arid), 0);
        chk("t6_rst_araddr", 128'(m_if.araddr), 0);
        chk("t6_rst_err", 128'(unrouted_err), 0);
        step();
        areset = 0;
        m_if.arready = 1;
        s1_if.arvalid = 1; s1_if.araddr = 32'h7000; s1_if.arid = 8'h00;
        #1;
        chk("t6_s1_grant_after_rst", 128'(s1_if.arready), 1);
        push_ar(32'h7000, 8'h10, 3'b000);
        step();
        s1_if.arvalid = 0;
        step();
        step();

        chk("end_ar_sb_empty", 128'(ar_sb.size()), 0);
        chk("end_r_sb_empty", 128'(r_sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
